// File: rtl/desc_pkg.sv
// Shared types for the descriptor memory and its fetch engine: descriptor layout and fetch FSM states.
package desc_pkg;

    localparam int DESC_W = 64;

    typedef struct packed {
        logic [15:0] src_address;
        logic [15:0] dst_address;
        logic [31:0] payload_ptr;
    } descriptor_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/descriptor_fetch_engine.sv
// Walks a run of descriptors in the descriptor memory (registered read) and streams
// each one out on a valid/ready port, optionally skipping entries with a null payload.
module descriptor_fetch_engine
    import desc_pkg::*;
#(
    parameter int NUM_DESCRIPTORS = 16,
    parameter int IDX_W           = $clog2(NUM_DESCRIPTORS),
    parameter bit SKIP_NULL       = 1'b1
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             start_i,
    input  logic [IDX_W-1:0] start_idx_i,
    input  logic [IDX_W:0]   count_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W-1:0] mem_addr_o,
    input  logic [15:0]      mem_src_address_i,
    input  logic [15:0]      mem_dst_address_i,
    input  logic [31:0]      mem_payload_ptr_i,
    output logic             desc_valid_o,
    input  logic             desc_ready_i,
    output logic [15:0]      desc_src_address_o,
    output logic [15:0]      desc_dst_address_o,
    output logic [31:0]      desc_payload_ptr_o,
    output logic [IDX_W-1:0] desc_index_o
);

    localparam logic [IDX_W:0] REM_ONE = (IDX_W+1)'(1);

    fetch_state_e     state_reg, state_next;
    logic [IDX_W-1:0] cur_idx_reg, cur_idx_next;
    logic [IDX_W:0]   remaining_reg, remaining_next;
    descriptor_t      desc_reg, desc_next;
    logic [IDX_W-1:0] index_reg, index_next;
    logic             valid_reg, valid_next;
    logic             done_reg, done_next;
    logic             zero_start;
    logic             payload_null;

    assign payload_null = SKIP_NULL && (mem_payload_ptr_i == 32'd0);

    always_comb begin
        state_next     = state_reg;
        cur_idx_next   = cur_idx_reg;
        remaining_next = remaining_reg;
        desc_next      = desc_reg;
        index_next     = index_reg;
        valid_next     = valid_reg;
        zero_start     = 1'b0;

        // Abort outranks handshake and start: the presented descriptor is simply dropped.
        if (state_reg != IDLE && abort_i) begin
            state_next = IDLE;
            valid_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        if (count_i == '0) begin
                            zero_start = 1'b1;
                        end else begin
                            cur_idx_next   = start_idx_i;
                            remaining_next = count_i;
                            state_next     = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_next = CAPTURE;
                end
                CAPTURE: begin
                    desc_next.src_address = mem_src_address_i;
                    desc_next.dst_address = mem_dst_address_i;
                    desc_next.payload_ptr = mem_payload_ptr_i;
                    index_next     = cur_idx_reg;
                    remaining_next = remaining_reg - REM_ONE;
                    // Index width equals log2 of depth, so the increment wraps naturally.
                    cur_idx_next   = cur_idx_reg + IDX_W'(1);
                    if (payload_null) begin
                        state_next = (remaining_reg > REM_ONE) ? ISSUE : DONE;
                    end else begin
                        state_next = PRESENT;
                        valid_next = 1'b1;
                    end
                end
                PRESENT: begin
                    if (desc_ready_i) begin
                        valid_next = 1'b0;
                        state_next = (remaining_reg != '0) ? ISSUE : DONE;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            endcase
        end

        done_next = zero_start || (state_next == DONE && state_reg != DONE);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_reg     <= IDLE;
            cur_idx_reg   <= '0;
            remaining_reg <= '0;
            desc_reg      <= '0;
            index_reg     <= '0;
            valid_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_idx_reg   <= cur_idx_next;
            remaining_reg <= remaining_next;
            desc_reg      <= desc_next;
            index_reg     <= index_next;
            valid_reg     <= valid_next;
            done_reg      <= done_next;
        end
    end

    // The read address register is the walking index itself.
    assign mem_addr_o         = cur_idx_reg;
    assign busy_o             = (state_reg != IDLE);
    assign done_o             = done_reg;
    assign desc_valid_o       = valid_reg;
    assign desc_src_address_o = desc_reg.src_address;
    assign desc_dst_address_o = desc_reg.dst_address;
    assign desc_payload_ptr_o = desc_reg.payload_ptr;
    assign desc_index_o       = index_reg;

endmodule
